// File: rtl/dadda_pkg.sv
// rtl/dadda_pkg.sv - shared constants and 4:2 approximate compressor functions
package dadda_pkg;

  localparam int W_MIN      = 4;
  localparam int W_MAX      = 16;
  localparam int K_MIN      = 0;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 3;

  // Largest legal K for a given operand width (columns 0..2W-2 may be approximated)
  function automatic int k_max(input int w);
    return 2 * w - 1;
  endfunction

  // Number of four-bit groups needed to cover the tallest column of a WxW array
  function automatic int num_groups(input int w);
    return (w + 3) / 4;
  endfunction

  function automatic logic cmp_sum(input logic x1, input logic x2,
                                   input logic x3, input logic x4);
    return (x1 ^ x2) | (x3 ^ x4);
  endfunction

  function automatic logic cmp_carry(input logic x1, input logic x2,
                                     input logic x3, input logic x4);
    return (x1 & x2) | (x3 & x4);
  endfunction

endpackage

// File: rtl/cmp4_2_approx.sv
// rtl/cmp4_2_approx.sv - combinational approximate 4:2 compressor
module cmp4_2_approx
  import dadda_pkg::*;
(
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  output logic sum,
  output logic carry
);

  assign sum   = cmp_sum(x1, x2, x3, x4);
  assign carry = cmp_carry(x1, x2, x3, x4);

endmodule

// File: rtl/dadda_approx_pipe_mult.sv
// rtl/dadda_approx_pipe_mult.sv - pipelined unsigned multiplier with approximate low columns
module dadda_approx_pipe_mult
  import dadda_pkg::*;
#(
  parameter int W      = 8,
  parameter int K      = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic             approx,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   O,
  output logic             O_approx,
  output logic [15:0]      txn_count
);

  localparam int PW = 2 * W;
  localparam int G  = num_groups(W);
  localparam int R  = W + 2 * G;
  // Columns at or above K keep their exact partial-product bits in approximate mode
  localparam logic [PW-1:0] HI_MASK = {PW{1'b1}} << K;

  // Column PW-1 is never approximated (K <= 2W-1), so group vectors stop at PW-2
  logic [PW-2:0] grp_sum   [G];
  logic [PW-2:0] grp_carry [G];
  logic [PW-1:0] rows      [R];
  logic [PW-1:0] red_s, red_c, csa_s;

  for (genvar c = 0; c < PW - 1; c++) begin : g_col
    localparam int LO = (c > W - 1) ? c - W + 1 : 0;
    localparam int HI = (c < W - 1) ? c : W - 1;
    if (c < K) begin : g_apx
      for (genvar g = 0; g < G; g++) begin : g_grp
        logic [3:0] x;
        for (genvar k = 0; k < 4; k++) begin : g_bit
          localparam int I = LO + 4 * g + k;
          if (I <= HI) begin : g_pp
            assign x[k] = A[c-I] & B[I];
          end else begin : g_pad
            assign x[k] = 1'b0;
          end
        end
        cmp4_2_approx u_cmp (
          .x1    (x[0]),
          .x2    (x[1]),
          .x3    (x[2]),
          .x4    (x[3]),
          .sum   (grp_sum[g][c]),
          .carry (grp_carry[g][c])
        );
      end
    end else begin : g_exact
      for (genvar g = 0; g < G; g++) begin : g_zero
        assign grp_sum[g][c]   = 1'b0;
        assign grp_carry[g][c] = 1'b0;
      end
    end
  end

  // Operand rows: shifted pp rows (low columns masked off when approximating) plus compressor outputs
  always_comb begin
    for (int i = 0; i < W; i++) begin
      rows[i] = {{W{1'b0}}, A & {W{B[i]}}} << i;
      if (approx) rows[i] = rows[i] & HI_MASK;
    end
    for (int g = 0; g < G; g++) begin
      rows[W+2*g]   = approx ? {1'b0, grp_sum[g]}   : '0;
      rows[W+2*g+1] = approx ? {grp_carry[g], 1'b0} : '0;
    end
  end

  // Carry-save reduction of all rows down to a redundant sum/carry pair
  always_comb begin
    red_s = '0;
    red_c = '0;
    csa_s = '0;
    for (int r = 0; r < R; r++) begin
      csa_s = red_s ^ red_c ^ rows[r];
      red_c = ((red_s & red_c) | (red_s & rows[r]) | (red_c & rows[r])) << 1;
      red_s = csa_s;
    end
  end

  logic [PW-1:0]     st_s [STAGES];
  logic [PW-1:0]     st_c [STAGES];
  logic [STAGES-1:0] st_m;
  logic [STAGES-1:0] st_v;
  logic [STAGES-1:0] load;
  logic              tail_full;
  logic              ready_en;

  // A stage may load when out_ready is high or some stage at or after it is empty
  always_comb begin
    tail_full = 1'b1;
    load      = '0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      tail_full = tail_full & st_v[s];
      load[s]   = out_ready | ~tail_full;
    end
  end

  assign in_ready  = ready_en & load[0];
  assign out_valid = st_v[STAGES-1];
  assign O_approx  = st_m[STAGES-1];
  assign O         = st_s[STAGES-1] + st_c[STAGES-1];

  // Stall-able pipeline registers, ready gating after reset, and completed-transfer counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      st_v      <= '0;
      st_m      <= '0;
      txn_count <= '0;
      for (int s = 0; s < STAGES; s++) begin
        st_s[s] <= '0;
        st_c[s] <= '0;
      end
    end else begin
      ready_en <= 1'b1;
      if (in_ready) begin
        st_v[0] <= in_valid;
        st_m[0] <= approx;
        st_s[0] <= red_s;
        st_c[0] <= red_c;
      end
      for (int s = 1; s < STAGES; s++) begin
        if (load[s]) begin
          st_v[s] <= st_v[s-1];
          st_m[s] <= st_m[s-1];
          st_s[s] <= st_s[s-1];
          st_c[s] <= st_c[s-1];
        end
      end
      if (out_valid && out_ready) txn_count <= txn_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_dadda_approx_pipe_mult.sv
// tb/tb_dadda_approx_pipe_mult.sv - self-checking bench for dadda_approx_pipe_mult
module tb_dadda_approx_pipe_mult;

  localparam int W   = 8;
  localparam int K1  = 8;
  localparam int STG = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  a1, b1, a0, b0;
  logic        m1, v1, ordy1, rdy1, ov1, oa1;
  logic        m0, v0, ordy0, rdy0, ov0, oa0;
  logic [15:0] o1, tc1, o0, tc0;

  dadda_approx_pipe_mult #(.W(W), .K(K1), .STAGES(STG)) dut (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .approx(m1),
    .in_valid(v1), .in_ready(rdy1), .out_valid(ov1), .out_ready(ordy1),
    .O(o1), .O_approx(oa1), .txn_count(tc1)
  );

  dadda_approx_pipe_mult #(.W(W), .K(0), .STAGES(STG)) dut0 (
    .clk(clk), .rst_n(rst_n), .A(a0), .B(b0), .approx(m0),
    .in_valid(v0), .in_ready(rdy0), .out_valid(ov0), .out_ready(ordy0),
    .O(o0), .O_approx(oa0), .txn_count(tc0)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Column-by-column model: bits of each column in ascending row order, groups of four
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic m, input int k);
    int unsigned acc;
    bit          bits [$];
    bit          x [4];
    int unsigned s, cy;
    acc = 0;
    if (!m) return 16'(a) * 16'(b);
    for (int c = 0; c < 2 * W - 1; c++) begin
      bits.delete();
      for (int i = 0; i < W; i++) begin
        int j = c - i;
        if (j >= 0 && j < W) bits.push_back(a[j] & b[i]);
      end
      if (c >= k) begin
        foreach (bits[n]) acc += int'(bits[n]) << c;
      end else begin
        for (int g = 0; g < bits.size(); g += 4) begin
          for (int q = 0; q < 4; q++) x[q] = (g + q < bits.size()) ? bits[g+q] : 1'b0;
          s  = int'((x[0] ^ x[1]) | (x[2] ^ x[3]));
          cy = int'((x[0] & x[1]) | (x[2] & x[3]));
          acc += (s << c) + (cy << (c + 1));
        end
      end
    end
    return acc[15:0];
  endfunction

  logic [16:0] exp_q [$];
  logic [16:0] exp0_q [$];
  logic [15:0] log_o [$];
  logic        log_m [$];
  int          log_cyc [$];
  int          acc_cyc [$];
  logic [15:0] cnt1, cnt0;

  task automatic clear_logs();
    log_o.delete();
    log_m.delete();
    log_cyc.delete();
    acc_cyc.delete();
  endtask

  // Compare process: checks both DUTs against the model every cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp0_q.delete();
      cnt1 = '0;
      cnt0 = '0;
      chk("rst_out_valid", 32'(ov1), 0);
      chk("rst_txn_count", 32'(tc1), 0);
    end else begin
      chk("txn_count", 32'(tc1), 32'(cnt1));
      if (ov1) begin
        if (exp_q.size() == 0) chk("spurious_out", 32'(ov1), 0);
        else begin
          chk("O", 32'(o1), 32'(exp_q[0][15:0]));
          chk("O_approx", 32'(oa1), 32'(exp_q[0][16]));
        end
        if (ordy1) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          log_o.push_back(o1);
          log_m.push_back(oa1);
          log_cyc.push_back(cyc);
          cnt1 = cnt1 + 16'd1;
        end
      end
      if (v1 && rdy1) begin
        exp_q.push_back({m1, model(a1, b1, m1, K1)});
        acc_cyc.push_back(cyc);
      end

      chk("txn_count0", 32'(tc0), 32'(cnt0));
      if (ov0) begin
        if (exp0_q.size() == 0) chk("spurious_out0", 32'(ov0), 0);
        else begin
          chk("O_k0", 32'(o0), 32'(exp0_q[0][15:0]));
          chk("O_approx_k0", 32'(oa0), 32'(exp0_q[0][16]));
        end
        if (ordy0) begin
          if (exp0_q.size() > 0) void'(exp0_q.pop_front());
          cnt0 = cnt0 + 16'd1;
        end
      end
      if (v0 && rdy0) exp0_q.push_back({m0, 16'(a0) * 16'(b0)});
    end
  end

  task automatic drive1(input logic [7:0] a, input logic [7:0] b, input logic m);
    bit acc;
    int n;
    a1 = a; b1 = b; m1 = m; v1 = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = rdy1;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int acc0;
    int n;
    a1 = '0; b1 = '0; m1 = 1'b0; v1 = 1'b0; ordy1 = 1'b1;
    a0 = '0; b0 = '0; m0 = 1'b0; v0 = 1'b0; ordy0 = 1'b1;

    chk("pin_ff_approx", 32'(model(8'hFF, 8'hFF, 1'b1, 8)), 32'h0000FB11);
    chk("pin_ff_exact", 32'(model(8'hFF, 8'hFF, 1'b0, 8)), 32'h0000FE01);
    chk("pin_ff_k0", 32'(model(8'hFF, 8'hFF, 1'b1, 0)), 32'h0000FE01);
    chk("pin_0f_approx", 32'(model(8'h0F, 8'h0F, 1'b1, 8)), 32'h000000D1);

    #1 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", 32'(ov1), 0);
    chk("reset_O", 32'(o1), 0);
    chk("reset_O_approx", 32'(oa1), 0);
    chk("reset_txn_count", 32'(tc1), 0);
    chk("reset_in_ready", 32'(rdy1), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk("ready_before_edge", 32'(rdy1), 0);
    @(posedge clk);
    #1 chk("ready_after_edge", 32'(rdy1), 1);

    clear_logs();
    drive1(8'hFF, 8'hFF, 1'b1);
    v1 = 1'b0;
    wait_cycles(5);
    chk("single_count", 32'(log_o.size()), 1);
    if (log_o.size() == 1 && acc_cyc.size() == 1) begin
      chk("single_O", 32'(log_o[0]), 32'h0000FB11);
      chk("single_tag", 32'(log_m[0]), 1);
      chk("single_latency", 32'(log_cyc[0] - acc_cyc[0]), STG);
    end

    clear_logs();
    drive1(8'hFF, 8'hFF, 1'b0);
    drive1(8'h00, 8'hA5, 1'b0);
    v1 = 1'b0;
    wait_cycles(5);
    chk("exact_count", 32'(log_o.size()), 2);
    if (log_o.size() == 2) begin
      chk("exact_ff", 32'(log_o[0]), 32'h0000FE01);
      chk("exact_zero", 32'(log_o[1]), 0);
      chk("exact_tag", 32'(log_m[0] | log_m[1]), 0);
    end

    clear_logs();
    drive1(8'hFF, 8'hFF, 1'b1);
    drive1(8'hFF, 8'hFF, 1'b0);
    drive1(8'hFF, 8'hFF, 1'b1);
    v1 = 1'b0;
    wait_cycles(5);
    chk("alt_count", 32'(log_o.size()), 3);
    if (log_o.size() == 3) begin
      chk("alt_O0", 32'(log_o[0]), 32'h0000FB11);
      chk("alt_O1", 32'(log_o[1]), 32'h0000FE01);
      chk("alt_O2", 32'(log_o[2]), 32'h0000FB11);
      chk("alt_tags", 32'({log_m[0], log_m[1], log_m[2]}), 32'h5);
      chk("alt_spacing1", 32'(log_cyc[1] - log_cyc[0]), 1);
      chk("alt_spacing2", 32'(log_cyc[2] - log_cyc[1]), 1);
    end

    clear_logs();
    ordy1 = 1'b0;
    drive1(8'h12, 8'h34, 1'b0);
    drive1(8'hFF, 8'hFF, 1'b1);
    a1 = 8'h0F; b1 = 8'h0F; m1 = 1'b1; v1 = 1'b1;
    wait_cycles(3);
    chk("bp_in_ready_low", 32'(rdy1), 0);
    chk("bp_accepts", 32'(acc_cyc.size()), STG);
    chk("bp_out_valid", 32'(ov1), 1);
    chk("bp_O_hold", 32'(o1), 32'h000003A8);
    ordy1 = 1'b1;
    drive1(8'h0F, 8'h0F, 1'b1);
    v1 = 1'b0;
    wait_cycles(6);
    chk("bp_count", 32'(log_o.size()), 3);
    if (log_o.size() == 3) begin
      chk("bp_O0", 32'(log_o[0]), 32'h000003A8);
      chk("bp_O1", 32'(log_o[1]), 32'h0000FB11);
      chk("bp_O2", 32'(log_o[2]), 32'h000000D1);
      chk("bp_tags", 32'({log_m[0], log_m[1], log_m[2]}), 32'h3);
    end

    drive1(8'hFF, 8'hFF, 1'b1);
    drive1(8'hFF, 8'hFF, 1'b0);
    v1 = 1'b0;
    #1 rst_n = 1'b0;
    clear_logs();
    #1;
    chk("flush_out_valid", 32'(ov1), 0);
    chk("flush_txn_count", 32'(tc1), 0);
    chk("flush_O", 32'(o1), 0);
    chk("flush_O_approx", 32'(oa1), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk("flush_ready_before_edge", 32'(rdy1), 0);
    @(posedge clk);
    #1 chk("flush_ready_after_edge", 32'(rdy1), 1);
    wait_cycles(6);
    chk("flush_no_output", 32'(log_o.size()), 0);

    acc0 = 0;
    n = 0;
    while (acc0 < 1000 && n < 5000) begin
      a0 = 8'($urandom);
      b0 = 8'($urandom);
      m0 = 1'($urandom_range(0, 1));
      v0 = ($urandom_range(0, 3) != 0);
      ordy0 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (v0 && rdy0) acc0++;
      @(posedge clk);
      #1;
      n++;
    end
    chk("k0_random_accepts", 32'(acc0), 1000);
    ordy0 = 1'b1;
    v0 = 1'b1;
    n = 0;
    while (acc0 < 65540 && n < 75000) begin
      a0 = 8'($urandom);
      b0 = 8'($urandom);
      m0 = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (rdy0) acc0++;
      @(posedge clk);
      #1;
      n++;
    end
    v0 = 1'b0;
    wait_cycles(6);
    chk("k0_total_accepts", 32'(acc0), 65540);
    chk("k0_wrap_count", 32'(tc0), 4);
    chk("k0_all_delivered", 32'(exp0_q.size()), 0);
    chk("main_all_delivered", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
